// File: rtl/ice40_ram_pkg.sv
// Shared constants and types for the iCE40 RAM-backed stream FIFO.
//   RAM_*      : SB_RAM40_4K port widths in 256x16 mode
//   FIFO_*     : logical FIFO geometry (8-bit address + wrap bit pointers)
//   *_MODE_*   : mode values the parent passes to the SB_RAM40_4K instance
package ice40_ram_pkg;

  localparam int unsigned RAM_AW     = 11;
  localparam int unsigned RAM_DW     = 16;
  localparam int unsigned FIFO_AW    = 8;
  localparam int unsigned FIFO_DEPTH = 256;
  localparam int unsigned PTR_W      = FIFO_AW + 1;
  localparam int unsigned CNT_W      = 9;
  localparam int unsigned OBUF_CW    = 2;

  localparam int unsigned READ_MODE_256X16  = 0;
  localparam int unsigned WRITE_MODE_256X16 = 0;

  typedef logic [RAM_DW-1:0] word_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // RAM address from the low pointer bits; upper address bits unused in 256x16 mode
  function automatic logic [RAM_AW-1:0] ram_addr(input logic [FIFO_AW-1:0] a);
    return RAM_AW'(a);
  endfunction

endpackage

// File: rtl/ice40_ram_fifo_ctrl_if.sv
// Stream + RAM-port bundle for ice40_ram_fifo_ctrl.
//   slave  : the FIFO controller (consumes producer/consumer/RAM read data)
//   master : the surrounding logic (producer, consumer and RAM instance)
interface ice40_ram_fifo_ctrl_if;

  logic                       FLUSH;
  ice40_ram_pkg::word_t       IN_DATA;
  logic                       IN_VALID;
  logic                       IN_READY;
  ice40_ram_pkg::word_t       OUT_DATA;
  logic                       OUT_VALID;
  logic                       OUT_READY;
  ice40_ram_pkg::cnt_t        COUNT;
  logic                       ALMOST_FULL;
  logic [10:0]                RAM_WADDR;
  ice40_ram_pkg::word_t       RAM_WDATA;
  logic                       RAM_WE;
  logic                       RAM_WCLKE;
  logic [15:0]                RAM_MASK;
  logic [10:0]                RAM_RADDR;
  logic                       RAM_RE;
  logic                       RAM_RCLKE;
  ice40_ram_pkg::word_t       RAM_RDATA;

  modport slave (
    input  FLUSH, IN_DATA, IN_VALID, OUT_READY, RAM_RDATA,
    output IN_READY, OUT_DATA, OUT_VALID, COUNT, ALMOST_FULL,
    output RAM_WADDR, RAM_WDATA, RAM_WE, RAM_WCLKE, RAM_MASK,
    output RAM_RADDR, RAM_RE, RAM_RCLKE
  );

  modport master (
    output FLUSH, IN_DATA, IN_VALID, OUT_READY, RAM_RDATA,
    input  IN_READY, OUT_DATA, OUT_VALID, COUNT, ALMOST_FULL,
    input  RAM_WADDR, RAM_WDATA, RAM_WE, RAM_WCLKE, RAM_MASK,
    input  RAM_RADDR, RAM_RE, RAM_RCLKE
  );

endinterface

// File: rtl/ice40_fifo_obuf.sv
// Two-entry valid/ready output buffer fed by RAM read data.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous clear, takes priority over push/pop
//   push       : push_data is written this edge
//   pop        : head word consumed this edge
//   head_data  : head register (first-word-fall-through output)
//   head_valid : buffer non-empty
//   cnt        : occupancy 0..2
module ice40_fifo_obuf
  import ice40_ram_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  word_t              push_data,
  input  logic               pop,
  output word_t              head_data,
  output logic               head_valid,
  output logic [OBUF_CW-1:0] cnt
);

  word_t              head_q, head_d;
  word_t              tail_q, tail_d;
  logic [OBUF_CW-1:0] cnt_q, cnt_d;

  // Next-state: head always holds the oldest word, tail only used when full
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            head_d = push_data;
            cnt_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = push_data;
          end else if (push) begin
            tail_d = push_data;
            cnt_d  = 2'd2;
          end else if (pop) begin
            cnt_d = 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_d = tail_q;
            if (push) begin
              tail_d = push_data;
            end else begin
              cnt_d = 2'd1;
            end
          end
        end
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data  = head_q;
  assign head_valid = (cnt_q != '0);
  assign cnt        = cnt_q;

endmodule

// File: rtl/ice40_ram_fifo_ctrl.sv
// Valid/ready stream FIFO built on one SB_RAM40_4K in 256x16 mode.
//   CLK         : single clock (parent ties RAM RCLK/WCLK to it)
//   ASYNCRESETN : async active-low reset
//   bus.FLUSH / IN_* / OUT_*     : stream side
//   bus.COUNT / ALMOST_FULL      : total occupancy (RAM + in-flight + obuf)
//   bus.RAM_*                    : RAM write/read port controls and read data
module ice40_ram_fifo_ctrl
  import ice40_ram_pkg::*;
#(
  parameter int unsigned AFULL_LEVEL = 240
) (
  input logic                   CLK,
  input logic                   ASYNCRESETN,
  ice40_ram_fifo_ctrl_if.slave  bus
);

  ptr_t               wr_ptr, wr_ptr_d;
  ptr_t               rd_ptr, rd_ptr_d;
  ptr_t               ram_cnt;
  logic               inflight, inflight_d;
  cnt_t               count_q, count_d;
  logic               afull_q, afull_d;
  logic [OBUF_CW-1:0] obuf_cnt;
  logic [2:0]         obuf_slots;
  logic               ram_full, ram_empty;
  logic               in_ready, push, pop, issue;
  word_t              out_data;
  logic               out_valid;

  // Wrap bit makes wr_ptr - rd_ptr span 0..256 and separate full from empty
  assign ram_cnt   = wr_ptr - rd_ptr;
  assign ram_full  = (ram_cnt == PTR_W'(FIFO_DEPTH));
  assign ram_empty = (ram_cnt == '0);

  assign in_ready = !ram_full && !bus.FLUSH;
  assign push     = bus.IN_VALID && in_ready;
  assign pop      = out_valid && bus.OUT_READY;

  // Issue a read only if the word will have an obuf slot when it lands;
  // pop never exceeds obuf_cnt so the subtraction cannot underflow
  assign obuf_slots = 3'(obuf_cnt) + 3'(inflight) - 3'(pop);
  assign issue      = !ram_empty && (obuf_slots < 3'd2) && !bus.FLUSH;

  // Next-state for pointers, in-flight flag and occupancy
  always_comb begin
    wr_ptr_d   = wr_ptr;
    rd_ptr_d   = rd_ptr;
    inflight_d = 1'b0;
    count_d    = count_q;
    if (bus.FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr + PTR_W'(1);
      end
      if (issue) begin
        rd_ptr_d   = rd_ptr + PTR_W'(1);
        inflight_d = 1'b1;
      end
      // RAM->inflight->obuf moves preserve the total; only push/pop change it
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    afull_d = (count_d >= CNT_W'(AFULL_LEVEL));
  end

  // State registers
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      count_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      inflight <= inflight_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
    end
  end

  // RDATA is valid the cycle after the RE edge, i.e. while inflight is set
  ice40_fifo_obuf u_obuf (
    .clk        (CLK),
    .rst_n      (ASYNCRESETN),
    .flush      (bus.FLUSH),
    .push       (inflight),
    .push_data  (bus.RAM_RDATA),
    .pop        (pop),
    .head_data  (out_data),
    .head_valid (out_valid),
    .cnt        (obuf_cnt)
  );

  assign bus.IN_READY    = in_ready;
  assign bus.OUT_DATA    = out_data;
  assign bus.OUT_VALID   = out_valid;
  assign bus.COUNT       = count_q;
  assign bus.ALMOST_FULL = afull_q;

  // RAM write port: combinational from current state and producer inputs
  assign bus.RAM_WADDR = ram_addr(wr_ptr[FIFO_AW-1:0]);
  assign bus.RAM_WDATA = bus.IN_DATA;
  assign bus.RAM_WE    = push;
  assign bus.RAM_WCLKE = 1'b1;
  assign bus.RAM_MASK  = '0;

  // RAM read port
  assign bus.RAM_RADDR = ram_addr(rd_ptr[FIFO_AW-1:0]);
  assign bus.RAM_RE    = issue;
  assign bus.RAM_RCLKE = 1'b1;

endmodule

// File: tb/tb_ice40_ram_fifo_ctrl.sv
// Scoreboard bench for ice40_ram_fifo_ctrl with a behavioural 256x16 RAM.
module tb_ice40_ram_fifo_ctrl;

  logic CLK;
  logic ASYNCRESETN;

  ice40_ram_fifo_ctrl_if bus ();

  ice40_ram_fifo_ctrl #(.AFULL_LEVEL(240)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .bus         (bus)
  );

  always #5 CLK = ~CLK;

  // SB_RAM40_4K-like model: registered read, data valid after the RE edge
  logic [15:0] mem [0:255];
  always @(posedge CLK) begin
    if (bus.RAM_WE && bus.RAM_WCLKE) mem[bus.RAM_WADDR[7:0]] <= bus.RAM_WDATA;
    if (bus.RAM_RE && bus.RAM_RCLKE) bus.RAM_RDATA <= mem[bus.RAM_RADDR[7:0]];
  end

  int          checks;
  int          errors;
  int          pops;
  logic [15:0] exp_q [$];

  // One clock cycle: sample handshakes at negedge, update scoreboard, return at posedge+1
  task automatic sb_cycle();
    logic [15:0] e;
    @(negedge CLK);
    if (!ASYNCRESETN) begin
      exp_q.delete();
    end else begin
      checks++;
      if (bus.COUNT !== 9'(exp_q.size())) begin
        errors++;
        $display("FAIL count_track: COUNT=%0d expected %0d at %0t", bus.COUNT, exp_q.size(), $time);
      end
      if (bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %h with empty scoreboard at %0t", bus.OUT_DATA, $time);
        end else begin
          e = exp_q.pop_front();
          if (bus.OUT_DATA !== e) begin
            errors++;
            $display("FAIL out_data: got %h expected %h at %0t", bus.OUT_DATA, e, $time);
          end
        end
      end
      if (bus.IN_VALID === 1'b1 && bus.IN_READY === 1'b1) exp_q.push_back(bus.IN_DATA);
      if (bus.FLUSH === 1'b1) exp_q.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      sb_cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words left after %0d cycles", name, exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    ASYNCRESETN = 1'b0;
    #12;
    checks++;
    if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0 || bus.OUT_DATA !== 16'h0) begin
      errors++;
      $display("FAIL reset_stream: in_ready=%b out_valid=%b out_data=%h expected 1 0 0000",
               bus.IN_READY, bus.OUT_VALID, bus.OUT_DATA);
    end
    checks++;
    if (bus.COUNT !== 9'd0 || bus.ALMOST_FULL !== 1'b0) begin
      errors++;
      $display("FAIL reset_count: count=%0d afull=%b expected 0 0", bus.COUNT, bus.ALMOST_FULL);
    end
    checks++;
    if (bus.RAM_WE !== 1'b0 || bus.RAM_RE !== 1'b0 || bus.RAM_MASK !== 16'h0 ||
        bus.RAM_WCLKE !== 1'b1 || bus.RAM_RCLKE !== 1'b1 ||
        bus.RAM_WADDR !== 11'd0 || bus.RAM_RADDR !== 11'd0) begin
      errors++;
      $display("FAIL reset_ram: we=%b re=%b mask=%h wclke=%b rclke=%b waddr=%h raddr=%h expected 0 0 0000 1 1 000 000",
               bus.RAM_WE, bus.RAM_RE, bus.RAM_MASK, bus.RAM_WCLKE, bus.RAM_RCLKE,
               bus.RAM_WADDR, bus.RAM_RADDR);
    end
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_single();
    int edges;
    bus.OUT_READY = 1'b1;
    bus.IN_DATA   = 16'hBEEF;
    bus.IN_VALID  = 1'b1;
    checks++;
    if (bus.IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL single_in_ready: got %b expected 1", bus.IN_READY);
    end
    sb_cycle();
    bus.IN_VALID = 1'b0;
    edges = 0;
    while (bus.OUT_VALID !== 1'b1 && edges < 10) begin
      sb_cycle();
      edges++;
    end
    checks++;
    if (edges != 2) begin
      errors++;
      $display("FAIL single_latency: out_valid after %0d edges expected 2", edges);
    end
    checks++;
    if (bus.OUT_DATA !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_data: got %h expected beef", bus.OUT_DATA);
    end
    sb_cycle();
    sb_cycle();
    checks++;
    if (bus.COUNT !== 9'd0 || bus.OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: count=%0d out_valid=%b expected 0 0", bus.COUNT, bus.OUT_VALID);
    end
  endtask

  task automatic test_stream();
    int lows;
    int n;
    lows = 0;
    pops = 0;
    bus.OUT_READY = 1'b1;
    bus.IN_VALID  = 1'b1;
    for (int i = 0; i < 512; i++) begin
      bus.IN_DATA = 16'(i);
      if (bus.IN_READY !== 1'b1) lows++;
      sb_cycle();
    end
    bus.IN_VALID = 1'b0;
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL stream_in_ready: low in %0d cycles expected 0", lows);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      sb_cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || n > 3) begin
      errors++;
      $display("FAIL stream_tail: %0d left after %0d cycles expected 0 within 3", exp_q.size(), n);
    end
    checks++;
    if (pops != 512) begin
      errors++;
      $display("FAIL stream_pops: got %0d expected 512", pops);
    end
  endtask

  task automatic test_full();
    int acc;
    int afbad;
    acc   = 0;
    afbad = 0;
    bus.OUT_READY = 1'b0;
    bus.IN_VALID  = 1'b1;
    for (int c = 0; c < 300; c++) begin
      bus.IN_DATA = 16'(acc);
      if (bus.ALMOST_FULL !== (exp_q.size() >= 240)) afbad++;
      if (bus.IN_READY === 1'b1) acc++;
      sb_cycle();
    end
    bus.IN_VALID = 1'b0;
    checks++;
    if (acc != 258) begin
      errors++;
      $display("FAIL full_accepted: got %0d expected 258", acc);
    end
    checks++;
    if (bus.COUNT !== 9'd258 || bus.IN_READY !== 1'b0 || bus.ALMOST_FULL !== 1'b1) begin
      errors++;
      $display("FAIL full_state: count=%0d in_ready=%b afull=%b expected 258 0 1",
               bus.COUNT, bus.IN_READY, bus.ALMOST_FULL);
    end
    checks++;
    if (afbad != 0) begin
      errors++;
      $display("FAIL full_afull_track: %0d cycles disagreed expected 0", afbad);
    end
    bus.OUT_READY = 1'b1;
    sb_cycle();
    checks++;
    if (bus.IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL full_reraise: in_ready=%b expected 1", bus.IN_READY);
    end
    drain(400, "full");
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      bus.IN_VALID  = ($urandom_range(0, 3) != 0);
      bus.OUT_READY = ($urandom_range(0, 2) != 0);
      bus.IN_DATA   = 16'($urandom);
      sb_cycle();
    end
    drain(400, "random");
  endtask

  task automatic test_flush();
    int n;
    bus.OUT_READY = 1'b0;
    bus.IN_VALID  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.IN_DATA = 16'hA000 + 16'(i);
      sb_cycle();
    end
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    sb_cycle();
    bus.OUT_READY = 1'b0;
    checks++;
    if (bus.COUNT !== 9'd5) begin
      errors++;
      $display("FAIL flush_setup: count=%0d expected 5", bus.COUNT);
    end
    bus.FLUSH    = 1'b1;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = 16'hDEAD;
    #1;
    checks++;
    if (bus.IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready: got %b expected 0", bus.IN_READY);
    end
    sb_cycle();
    bus.FLUSH    = 1'b0;
    bus.IN_VALID = 1'b0;
    checks++;
    if (bus.COUNT !== 9'd0 || bus.OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: count=%0d out_valid=%b expected 0 0", bus.COUNT, bus.OUT_VALID);
    end
    sb_cycle();
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL flush_stale: out_valid=%b expected 0", bus.OUT_VALID);
    end
    bus.IN_DATA   = 16'h1234;
    bus.IN_VALID  = 1'b1;
    bus.OUT_READY = 1'b1;
    sb_cycle();
    bus.IN_VALID = 1'b0;
    n = 0;
    while (bus.OUT_VALID !== 1'b1 && n < 10) begin
      sb_cycle();
      n++;
    end
    checks++;
    if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 16'h1234) begin
      errors++;
      $display("FAIL flush_next_word: valid=%b data=%h expected 1 1234", bus.OUT_VALID, bus.OUT_DATA);
    end
    drain(10, "flush");
  endtask

  task automatic test_async_reset();
    int stale;
    bus.OUT_READY = 1'b1;
    bus.IN_VALID  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.IN_DATA = 16'h5000 + 16'(i);
      sb_cycle();
    end
    #2;
    ASYNCRESETN  = 1'b0;
    bus.IN_VALID = 1'b0;
    #1;
    checks++;
    if (bus.OUT_VALID !== 1'b0 || bus.OUT_DATA !== 16'h0 || bus.COUNT !== 9'd0 ||
        bus.IN_READY !== 1'b1 || bus.ALMOST_FULL !== 1'b0 ||
        bus.RAM_RE !== 1'b0 || bus.RAM_WE !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h count=%0d in_ready=%b afull=%b re=%b we=%b expected 0 0000 0 1 0 0 0",
               bus.OUT_VALID, bus.OUT_DATA, bus.COUNT, bus.IN_READY, bus.ALMOST_FULL,
               bus.RAM_RE, bus.RAM_WE);
    end
    exp_q.delete();
    @(negedge CLK);
    #1;
    ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.OUT_VALID === 1'b1) stale++;
      sb_cycle();
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL async_stale: out_valid seen %0d cycles expected 0", stale);
    end
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.IN_DATA = 16'h6000 + 16'(i);
      sb_cycle();
    end
    drain(10, "async");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    CLK           = 1'b0;
    ASYNCRESETN   = 1'b0;
    bus.FLUSH     = 1'b0;
    bus.IN_DATA   = '0;
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b0;
    checks        = 0;
    errors        = 0;
    pops          = 0;

    test_reset();
    test_single();
    test_stream();
    test_full();
    test_random();
    test_flush();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ice40_ram_fifo_ctrl.md
# ice40_ram_fifo_ctrl

Synchronous FIFO controller that drives one SB_RAM40_4K primitive in 256x16 mode (READ_MODE=0, WRITE_MODE=0) and turns it into a valid/ready stream FIFO. It sits on both sides of the RAM instance:
- It generates the write-port signals (WADDR/WDATA/WE/WCLKE/MASK) and the read-port controls (RADDR/RE/RCLKE).
- It consumes RDATA into a 2-entry output buffer, giving first-word-fall-through output at full throughput.

Both RAM clocks are tied to CLK by the parent.

## Interface
Parameters:
- AFULL_LEVEL, 240, ALMOST_FULL asserts when COUNT >= AFULL_LEVEL (legal 1..258)

Ports:
- CLK  in  1  single clock; also drives RAM RCLK and WCLK in the parent
- ASYNCRESETN  in  1  reset, asynchronous assert, active-low
- FLUSH  in  1  synchronous clear of all contents
- IN_DATA  in  16  write word
- IN_VALID  in  1  producer has a word
- IN_READY  out  1  FIFO accepts a word this cycle
- OUT_DATA  out  16  head word
- OUT_VALID  out  1  head word valid
- OUT_READY  in  1  consumer takes the head word
- COUNT  out  9  total occupancy (RAM + in-flight + output buffer), 0..258
- ALMOST_FULL  out  1  see AFULL_LEVEL
- RAM_WADDR  out  11  write address
- RAM_WDATA  out  16  write data
- RAM_WE, RAM_WCLKE  out  1  write enable / write clock enable
- RAM_MASK  out  16  bit mask; constant 0, i.e. all bits written
- RAM_RADDR  out  11  read address
- RAM_RE, RAM_RCLKE  out  1  read enable / read clock enable
- RAM_RDATA  in  16  RAM read data, valid the cycle after the RE edge

## Operation
**Pointers**
- wr_ptr and rd_ptr are 9 bits: 8-bit address plus a wrap bit.
- ram_cnt = wr_ptr - rd_ptr, range 0..256. RAM full when ram_cnt == 256.
- RAM_WADDR = {3'b0, wr_ptr[7:0]}; RAM_RADDR = {3'b0, rd_ptr[7:0]}.

**Push**
- IN_READY = (ram_cnt != 256) && !FLUSH.
- On IN_VALID && IN_READY: RAM_WE = 1, RAM_WDATA = IN_DATA, and wr_ptr increments at the edge.
- RAM_WE, RAM_WDATA and RAM_WADDR are combinational from the current state and inputs.
- RAM_WCLKE and RAM_RCLKE are held at 1.

**Read issue**
- RAM_RE = (ram_cnt != 0) && (obuf_cnt + inflight - pop < 2) && !FLUSH, where pop = OUT_VALID && OUT_READY.
- On issue, rd_ptr increments and the inflight flag is set for one cycle.
- Empty detection uses registered pointers. A word written at edge E is first readable at edge E+1, so same-address read/write collision cannot occur.

**Output buffer**
- 2-entry FIFO; OUT_DATA is its head register.
- When inflight is set, RAM_RDATA is written into the buffer at the next edge.
- Push and pop in the same cycle are legal, including when the buffer holds 1 entry or is full.

**Other rules**
- COUNT = ram_cnt + inflight + obuf_cnt, registered.
- FLUSH: at the next edge the pointers, inflight, obuf and COUNT all go to 0. Any push or issue in that cycle is suppressed, and the in-flight read data is discarded.
- Reset values: all state 0. Outputs: IN_READY=1, OUT_VALID=0, OUT_DATA=0, COUNT=0, ALMOST_FULL=0, RAM_WE=0, RAM_RE=0, RAM_MASK=0, RAM_WCLKE=RAM_RCLKE=1. Reset mid-operation discards everything.

## Timing
- **Latency:** word accepted at edge E → RAM_RE high in the cycle after E, with RAM sampling at E+1 → captured into obuf at E+2 → OUT_VALID high after E+2. Empty-to-output latency is 2 cycles.
- **Throughput:** sustained 1 word/cycle in and out when OUT_READY is held high.
- **Backpressure:** when OUT_READY drops, at most 1 in-flight word lands and fills obuf to 2; no data is lost.
- **Full:** IN_READY falls in the cycle after the push that makes ram_cnt 256. A pop from RAM re-raises it the following cycle.
- **Wrap:** the address wraps 255→0 with the wrap bit toggling. Full vs empty is distinguished by the wrap bit.

## Structure
- Package ice40_ram_pkg holds:
  - RAM_AW=11, RAM_DW=16, FIFO_AW=8, FIFO_DEPTH=256
  - READ_MODE_256X16=0, WRITE_MODE_256X16=0
- Sub-module ice40_fifo_obuf: 2-entry valid/ready buffer with push, pop, 16-bit data and a 2-bit count.
- Top level holds pointers, issue logic, COUNT and ALMOST_FULL.
- The parent instantiates SB_RAM40_4K with matching modes.

## Test plan
- Reset, then push 1 word 0xBEEF with OUT_READY=1 → OUT_VALID high exactly 2 cycles after acceptance with OUT_DATA=0xBEEF; COUNT returns to 0.
- Stream 0x0000..0x01FF with both sides always ready → 1 word/cycle, in-order output, IN_READY never low, pointers wrap twice.
- OUT_READY=0 while pushing 300 words → IN_READY low after 258 accepted (COUNT=258), ALMOST_FULL high from COUNT=240; then drain and verify order 0..257.
- Toggle OUT_READY pseudo-randomly while pushing random data → scoreboard exact match, COUNT always equals scoreboard depth.
- FLUSH asserted with COUNT=5 and a read in flight → next cycle COUNT=0, OUT_VALID=0; a subsequent push of 0x1234 is the next word out.
- ASYNCRESETN pulsed low mid-stream (between edges) → outputs take reset values immediately, no stale word appears after release.
